// File: rtl/alu_req_scheduler.sv
// Round-robin two-port scheduler for the shared ALU datapath.
// Grants one command at a time, holds ALU inputs, returns a tagged response.
module alu_req_scheduler #(
    parameter int WIDTH  = 4,
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [2:0]       req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [2:0]       req1_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_op,
    input  logic [WIDTH-1:0] alu_res,
    input  logic             alu_n,
    input  logic             alu_z,
    input  logic             alu_c,
    input  logic             alu_v,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_res,
    output logic [3:0]       rsp_flags,
    output logic             rsp_err,
    output logic             busy,
    output logic [7:0]       op_count
);

    typedef enum logic [1:0] {IDLE, ISSUE, RESPOND} state_e;

    localparam logic [3:0] SETTLE_C = 4'(SETTLE);

    state_e           state_q, state_d;
    logic             last_q, last_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic [2:0]       alu_op_q, alu_op_d;
    logic             rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0] rsp_res_q, rsp_res_d;
    logic [3:0]       rsp_flags_q, rsp_flags_d;
    logic             rsp_err_q, rsp_err_d;
    logic [7:0]       op_count_q, op_count_d;

    logic             gnt;
    logic             hs;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic [2:0]       sel_op;

    // On a tie the requester not served last wins; a lone valid always wins.
    assign gnt        = (req0_valid && req1_valid) ? ~last_q : req1_valid;
    assign req0_ready = (state_q == IDLE) && req0_valid && !gnt;
    assign req1_ready = (state_q == IDLE) && req1_valid && gnt;
    assign hs         = req0_ready || req1_ready;
    assign sel_a      = gnt ? req1_a  : req0_a;
    assign sel_b      = gnt ? req1_b  : req0_b;
    assign sel_op     = gnt ? req1_op : req0_op;

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_op_d    = alu_op_q;
        rsp_id_d    = rsp_id_q;
        rsp_res_d   = rsp_res_q;
        rsp_flags_d = rsp_flags_q;
        rsp_err_d   = rsp_err_q;
        op_count_d  = op_count_q;
        unique case (state_q)
            IDLE: begin
                if (hs) begin
                    rsp_id_d = gnt;
                    if (sel_op == 3'd7) begin
                        rsp_res_d   = '0;
                        rsp_flags_d = '0;
                        rsp_err_d   = 1'b1;
                        state_d     = RESPOND;
                    end else begin
                        alu_a_d  = sel_a;
                        alu_b_d  = sel_b;
                        alu_op_d = sel_op;
                        cnt_d    = SETTLE_C;
                        state_d  = ISSUE;
                    end
                end
            end
            ISSUE: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    rsp_res_d   = alu_res;
                    rsp_flags_d = {alu_n, alu_z, alu_c, alu_v};
                    rsp_err_d   = 1'b0;
                    state_d     = RESPOND;
                end
            end
            RESPOND: begin
                if (rsp_ready) begin
                    last_d     = rsp_id_q;
                    op_count_d = op_count_q + 8'd1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q      <= 1'b1;
            cnt_q       <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= '0;
            rsp_id_q    <= 1'b0;
            rsp_res_q   <= '0;
            rsp_flags_q <= '0;
            rsp_err_q   <= 1'b0;
            op_count_q  <= '0;
        end else begin
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_op_q    <= alu_op_d;
            rsp_id_q    <= rsp_id_d;
            rsp_res_q   <= rsp_res_d;
            rsp_flags_q <= rsp_flags_d;
            rsp_err_q   <= rsp_err_d;
            op_count_q  <= op_count_d;
        end
    end

    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_op    = alu_op_q;
    assign rsp_valid = (state_q == RESPOND);
    assign rsp_id    = rsp_id_q;
    assign rsp_res   = rsp_res_q;
    assign rsp_flags = rsp_flags_q;
    assign rsp_err   = rsp_err_q;
    assign busy      = (state_q != IDLE);
    assign op_count  = op_count_q;

endmodule

// File: tb/tb_alu_req_scheduler.sv
// Directed bench for alu_req_scheduler: vector table plus corner sequences.
// A stub ALU computes results; its flags come from a bench-set pattern.
module tb_alu_req_scheduler;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       r0v = 1'b0, r1v = 1'b0;
    logic [3:0] r0a = '0, r0b = '0, r1a = '0, r1b = '0;
    logic [2:0] r0op = '0, r1op = '0;
    logic       rr = 1'b1;
    logic [3:0] stub_fl = '0;

    logic       r0rdy, r1rdy;
    logic [3:0] aa, ab, ares;
    logic [2:0] aop;
    logic       an, az, ac, av;
    logic       rv, rid, rerr, busy;
    logic [3:0] rres, rfl;
    logic [7:0] cnt;

    logic       s0v = 1'b0, s1v = 1'b0;
    logic       rr3 = 1'b1;
    logic       s0rdy, s1rdy;
    logic [3:0] aa3, ab3, ares3;
    logic [2:0] aop3;
    logic       an3, az3, ac3, av3;
    logic       rv3, rid3, rerr3, busy3;
    logic [3:0] rres3, rfl3;
    logic [7:0] cnt3;

    int checks = 0;
    int failures = 0;
    int exp_cnt = 0;

    function automatic logic [3:0] alu_f(logic [3:0] a, logic [3:0] b,
                                         logic [2:0] op);
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a >> 1;
            3'd3: return a << 1;
            3'd4: return a & b;
            3'd5: return a | b;
            3'd6: return a ^ b;
            default: return 4'd0;
        endcase
    endfunction

    assign ares  = alu_f(aa, ab, aop);
    assign ares3 = alu_f(aa3, ab3, aop3);
    assign {an, az, ac, av}     = stub_fl;
    assign {an3, az3, ac3, av3} = stub_fl;

    alu_req_scheduler #(.WIDTH(4), .SETTLE(1)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(r0v), .req0_ready(r0rdy),
        .req0_a(r0a), .req0_b(r0b), .req0_op(r0op),
        .req1_valid(r1v), .req1_ready(r1rdy),
        .req1_a(r1a), .req1_b(r1b), .req1_op(r1op),
        .alu_a(aa), .alu_b(ab), .alu_op(aop),
        .alu_res(ares), .alu_n(an), .alu_z(az), .alu_c(ac), .alu_v(av),
        .rsp_valid(rv), .rsp_ready(rr), .rsp_id(rid),
        .rsp_res(rres), .rsp_flags(rfl), .rsp_err(rerr),
        .busy(busy), .op_count(cnt)
    );

    alu_req_scheduler #(.WIDTH(4), .SETTLE(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(s0v), .req0_ready(s0rdy),
        .req0_a(r0a), .req0_b(r0b), .req0_op(r0op),
        .req1_valid(s1v), .req1_ready(s1rdy),
        .req1_a(r1a), .req1_b(r1b), .req1_op(r1op),
        .alu_a(aa3), .alu_b(ab3), .alu_op(aop3),
        .alu_res(ares3), .alu_n(an3), .alu_z(az3), .alu_c(ac3), .alu_v(av3),
        .rsp_valid(rv3), .rsp_ready(rr3), .rsp_id(rid3),
        .rsp_res(rres3), .rsp_flags(rfl3), .rsp_err(rerr3),
        .busy(busy3), .op_count(cnt3)
    );

    typedef struct {
        logic       id;
        logic [3:0] a;
        logic [3:0] b;
        logic [2:0] op;
        logic [3:0] fl;
        logic [3:0] eres;
        logic [3:0] efl;
        logic       eerr;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        r0v = 1'b0;
        r1v = 1'b0;
        s0v = 1'b0;
        s1v = 1'b0;
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
        exp_cnt = 0;
    endtask

    task automatic wait_rsp(output int lat);
        lat = 0;
        while (!rv && lat < 20) begin
            step();
            lat++;
        end
    endtask

    task automatic issue(input logic id, input logic [3:0] a,
                         input logic [3:0] b, input logic [2:0] op);
        int t;
        t = 0;
        if (id) begin
            r1a = a; r1b = b; r1op = op; r1v = 1'b1;
        end else begin
            r0a = a; r0b = b; r0op = op; r0v = 1'b1;
        end
        #1;
        while (!(id ? r1rdy : r0rdy) && t < 20) begin
            step();
            t++;
        end
        chk("ready_seen", 32'(id ? r1rdy : r0rdy), 32'd1);
        step();
        if (id) r1v = 1'b0;
        else    r0v = 1'b0;
    endtask

    initial begin
        int lat;
        logic [9:0] snap;
        logic [10:0] prev_alu;
        int n, cyc, last_hs, gap, min_gap;
        logic hs_now, done_now, seen;

        vecs[0] = '{1'b0, 4'd3,  4'd5,  3'd0, 4'b0000, 4'd8,  4'b0000, 1'b0};
        vecs[1] = '{1'b1, 4'd2,  4'd7,  3'd1, 4'b1010, 4'd11, 4'b1010, 1'b0};
        vecs[2] = '{1'b0, 4'd9,  4'd0,  3'd2, 4'b0110, 4'd4,  4'b0110, 1'b0};
        vecs[3] = '{1'b1, 4'd9,  4'd0,  3'd3, 4'b1001, 4'd2,  4'b1001, 1'b0};
        vecs[4] = '{1'b1, 4'd12, 4'd10, 3'd6, 4'b0001, 4'd6,  4'b0001, 1'b0};
        vecs[5] = '{1'b1, 4'd15, 4'd15, 3'd7, 4'b1111, 4'd0,  4'b0000, 1'b1};
        vecs[6] = '{1'b0, 4'd8,  4'd8,  3'd0, 4'b0111, 4'd0,  4'b0111, 1'b0};

        do_reset();
        chk("rst_ready", 32'({r0rdy, r1rdy}), 32'd0);
        chk("rst_busy_valid", 32'({busy, rv}), 32'd0);
        chk("rst_alu", 32'({aa, ab, aop}), 32'd0);
        chk("rst_rsp", 32'({rid, rres, rfl, rerr}), 32'd0);
        chk("rst_count", 32'(cnt), 32'd0);

        rr = 1'b1;
        for (int i = 0; i < 7; i++) begin
            stub_fl = vecs[i].fl;
            prev_alu = {aa, ab, aop};
            issue(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].op);
            if (vecs[i].op != 3'd7)
                chk("alu_drive", 32'({aa, ab, aop}),
                    32'({vecs[i].a, vecs[i].b, vecs[i].op}));
            else
                chk("alu_hold_op7", 32'({aa, ab, aop}), 32'(prev_alu));
            chk("busy_on", 32'(busy), 32'd1);
            wait_rsp(lat);
            chk("latency", 32'(lat), (vecs[i].op == 3'd7) ? 32'd0 : 32'd1);
            chk("rsp_id", 32'(rid), 32'(vecs[i].id));
            chk("rsp_res", 32'(rres), 32'(vecs[i].eres));
            chk("rsp_flags", 32'(rfl), 32'(vecs[i].efl));
            chk("rsp_err", 32'(rerr), 32'(vecs[i].eerr));
            step();
            exp_cnt++;
            chk("op_count", 32'(cnt), 32'(exp_cnt));
            chk("busy_off", 32'(busy), 32'd0);
        end

        do_reset();
        r0a = 4'd12; r0b = 4'd10; r0op = 3'd4;
        r1a = 4'd12; r1b = 4'd10; r1op = 3'd5;
        r0v = 1'b1; r1v = 1'b1;
        #1;
        chk("tie1_grant", 32'({r0rdy, r1rdy}), 32'b10);
        step();
        r0v = 1'b0;
        wait_rsp(lat);
        chk("tie1_rsp", 32'({rid, rres}), 32'({1'b0, 4'd8}));
        step();
        chk("tie1_next", 32'({r0rdy, r1rdy}), 32'b01);
        step();
        r1v = 1'b0;
        wait_rsp(lat);
        chk("tie2_rsp", 32'({rid, rres}), 32'({1'b1, 4'd14}));
        step();
        exp_cnt += 2;
        chk("tie_count", 32'(cnt), 32'(exp_cnt));
        r0v = 1'b1; r1v = 1'b1;
        #1;
        chk("tie3_grant", 32'({r0rdy, r1rdy}), 32'b10);
        step();
        r0v = 1'b0; r1v = 1'b0;
        wait_rsp(lat);
        step();
        exp_cnt++;

        rr = 1'b0;
        stub_fl = 4'b0101;
        issue(1'b0, 4'd2, 4'd7, 3'd1);
        wait_rsp(lat);
        chk("bp_res", 32'({rid, rres, rfl, rerr}),
            32'({1'b0, 4'd11, 4'b0101, 1'b0}));
        snap = {rid, rres, rfl, rerr};
        r0v = 1'b1; r1v = 1'b1;
        stub_fl = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_hold", 32'({rv, rid, rres, rfl, rerr, r0rdy, r1rdy}),
                32'({1'b1, snap, 2'b00}));
        end
        chk("bp_count", 32'(cnt), 32'(exp_cnt));
        r0v = 1'b0; r1v = 1'b0;
        rr = 1'b1;
        step();
        exp_cnt++;
        chk("bp_done", 32'({busy, cnt}), 32'({1'b0, 8'(exp_cnt)}));

        r0a = 4'd5; r0b = 4'd6; r0op = 3'd0;
        s0v = 1'b1;
        #1;
        chk("s3_ready", 32'(s0rdy), 32'd1);
        step();
        s0v = 1'b0;
        chk("s3_issue", 32'({busy3, aa3, ab3}), 32'({1'b1, 4'd5, 4'd6}));
        step();
        chk("s3_mid", 32'({busy3, rv3}), 32'b10);
        rst_n = 1'b0;
        #1;
        chk("s3_rst_ctl", 32'({busy3, rv3, cnt3}), 32'd0);
        chk("s3_rst_alu", 32'({aa3, ab3, aop3}), 32'd0);
        chk("s3_rst_rsp", 32'({rid3, rres3, rfl3, rerr3}), 32'd0);
        step();
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            seen = seen | rv3;
        end
        chk("s3_no_rsp", 32'(seen), 32'd0);
        s0v = 1'b1; s1v = 1'b1;
        #1;
        chk("s3_tie", 32'({s0rdy, s1rdy}), 32'b10);
        s0v = 1'b0; s1v = 1'b0;
        exp_cnt = 0;

        step();
        chk("wrap_start", 32'(cnt), 32'd0);
        r0a = 4'd5; r0b = 4'd3; r0op = 3'd6;
        rr = 1'b1;
        r0v = 1'b1;
        #1;
        n = 0; cyc = 0; last_hs = -1; min_gap = 1000;
        while (n < 256 && cyc < 2000) begin
            hs_now = r0rdy;
            done_now = rv && rr;
            step();
            cyc++;
            if (hs_now) begin
                if (last_hs >= 0) begin
                    gap = cyc - last_hs;
                    if (gap < min_gap) min_gap = gap;
                end
                last_hs = cyc;
            end
            if (done_now) begin
                n++;
                if (n == 255) chk("wrap_255", 32'(cnt), 32'd255);
                if (n == 256) chk("wrap_0", 32'(cnt), 32'd0);
            end
        end
        r0v = 1'b0;
        chk("wrap_done", 32'(n), 32'd256);
        chk("wrap_gap", 32'(min_gap), 32'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_req_scheduler.md
# alu_req_scheduler

Sequencer and two-port arbiter for the shared 4-bit ALU datapath. Two requesters, such as the switch/button front end and a test-pattern generator, each submit operand/opcode commands over a valid/ready handshake. The block grants the ALU round-robin, drives the ALU inputs, waits a fixed settle time, then captures the result and N/Z/C/V flags. It returns them to the winning requester over a single tagged response channel and sits between the requesters and the combinational ALU.

## Interface

Parameters:
- WIDTH, 4, operand/result width; must match the ALU.
- SETTLE, 1, number of cycles the ALU inputs are held before the result is sampled; legal range 1..15.

Ports (clock and reset first):
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0_valid  in  1  requester 0 has a command.
- req0_ready  out  1  requester 0 command accepted this cycle when valid is also high.
- req0_a, req0_b  in  WIDTH  requester 0 operands.
- req0_op  in  3  requester 0 opcode.
- req1_valid, req1_ready, req1_a, req1_b, req1_op  same as the req0 group, for requester 1.
- alu_a, alu_b  out  WIDTH  operands to the ALU.
- alu_op  out  3  opcode to the ALU: 0 add, 1 sub, 2 shift right, 3 shift left, 4 and, 5 or, 6 xor.
- alu_res  in  WIDTH  ALU result.
- alu_n, alu_z, alu_c, alu_v  in  1  ALU flags.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts response.
- rsp_id  out  1  requester that issued the command.
- rsp_res  out  WIDTH  captured result.
- rsp_flags  out  4  captured {N,Z,C,V}.
- rsp_err  out  1  illegal opcode (7).
- busy  out  1  state is not IDLE.
- op_count  out  8  completed-response counter.

## Operation

FSM states are IDLE, ISSUE and RESPOND.

**IDLE**
- Grant selection:
  - Only one valid: grant it.
  - Both valid: grant the requester not served last. The last-served pointer resets to 1, so req0 wins the first tie.
- reqX_ready = (state==IDLE) && (grant==X). This is combinational from the valid inputs. Ready is never high for both requesters.
- On a handshake, the operands, opcode and id are registered into the command register.
  - Opcode 0..6: go to ISSUE and load the settle counter with SETTLE.
  - Opcode 7: go directly to RESPOND with rsp_res=0, rsp_flags=0, rsp_err=1. The ALU is not driven with the new command.

**ISSUE**
- alu_a/alu_b/alu_op come from the command register and are stable for the whole state.
- The counter decrements each cycle.
- On the edge where the counter equals 1: capture alu_res and the flags into the response registers, set rsp_err=0, go to RESPOND.

**RESPOND**
- rsp_valid=1. All rsp_* outputs are held constant until rsp_valid && rsp_ready.
- On that edge:
  - go to IDLE;
  - update the last-served pointer to rsp_id;
  - increment op_count, wrapping 255 to 0.
- Error responses count as well.

**General rules**
- alu_* hold their last driven value outside ISSUE. They are never changed by an opcode-7 command.
- Flags are passed through exactly as the ALU produces them. The block does not recompute them.

**Reset** (asynchronous, any state, including mid-ISSUE or mid-RESPOND)
- state=IDLE.
- All of these are 0: rsp_valid, rsp_res, rsp_flags, rsp_err, rsp_id, alu_a, alu_b, alu_op, op_count, busy.
- Last-served pointer is 1.
- An in-flight command is dropped with no response.

## Timing

- Handshake at edge k: busy=1 and alu_* are valid from k. rsp_valid rises after edge k+SETTLE.
  - With SETTLE=1, the response is visible 2 cycles after the request cycle.
- Opcode 7: rsp_valid rises after edge k, a latency of 1.
- Response accepted at edge m: ready can be high again in cycle m+1.
  - Minimum issue interval is SETTLE+2 cycles.
- No new command is accepted while busy. Requesters must hold valid and the command fields stable until ready.
- Outputs are registered, except req0_ready and req1_ready.

## Test plan

- **Single add:** req0 a=3, b=5, op=0, rsp_ready=1.
  - ALU inputs 3/5/0 during ISSUE.
  - rsp_res=8, rsp_flags=0000, rsp_id=0, 2 cycles after the request.
  - op_count=1.
- **Simultaneous requests out of reset:** req0 op=4 (a=12, b=10); req1 op=5 (a=12, b=10), both valid.
  - First response id=0, res=8.
  - Second response id=1, res=14.
  - Then a new tie grants req0 again, because req1 was served last.
- **Backpressure:** sub a=2, b=7 with rsp_ready=0 for 5 cycles.
  - rsp_valid and all rsp_* stay stable for all 5 cycles.
  - Neither ready rises.
  - Completion occurs only on the cycle rsp_ready=1.
- **Illegal opcode:** req1 op=7.
  - rsp_valid after 1 cycle with rsp_err=1, res=0, flags=0000, id=1.
  - alu_op is unchanged from its previous value.
  - op_count increments.
- **Reset mid-ISSUE, SETTLE=3:** assert rst_n=0 one cycle after the handshake.
  - All outputs return to their reset values immediately.
  - No response is produced.
  - The next tie grants req0.
- **Counter wrap:** run 256 back-to-back xor commands.
  - op_count goes 255 to 0.
  - Each issue interval is at least SETTLE+2 cycles.
